// File: rtl/axis_video_pattern_gen.sv
// axis_video_pattern_gen: AXI4-Stream RGB test-pattern frame source.
// Optional inter-frame gap: define VIDGEN_INTERFRAME_GAP_EN.
module axis_video_pattern_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int DATA_WIDTH = 24
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic [1:0]            mode,
   input  logic [DATA_WIDTH-1:0] solid_color,
`ifdef VIDGEN_INTERFRAME_GAP_EN
   input  logic [7:0]            frame_gap,
`endif
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   output logic                  busy,
   output logic [15:0]           frame_cnt
);

   localparam logic [15:0] X_LAST   = 16'(H_ACTIVE - 1);
   localparam logic [15:0] Y_LAST   = 16'(V_ACTIVE - 1);
   localparam logic [15:0] BAR_LAST = 16'(H_ACTIVE / 8 - 1);

`ifdef VIDGEN_INTERFRAME_GAP_EN
   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_ACTIVE} state_t;
`endif

   state_t                  state_q;
   logic [15:0]             x_q, y_q, x_d, y_d;
   logic [15:0]             sub_q, sub_d;
   logic [2:0]              bar_q, bar_d;
   logic [1:0]              mode_q;
   logic [DATA_WIDTH-1:0]   color_q;
   logic [DATA_WIDTH-1:0]   tdata_q;
   logic                    tvalid_q, tlast_q, tuser_q, busy_q;
   logic [15:0]             frame_cnt_q;
`ifdef VIDGEN_INTERFRAME_GAP_EN
   logic [7:0]              gap_q;
`endif

   logic                    xfer, last_x, last_y, eof;
   logic                    gap_take, gap_done, start;
   logic [DATA_WIDTH-1:0]   pix_nxt, pix_first;

   function automatic logic [23:0] bar_color(input logic [2:0] b);
      case (b)
         3'd0:    return 24'hFFFFFF;
         3'd1:    return 24'hFFFF00;
         3'd2:    return 24'h00FFFF;
         3'd3:    return 24'h00FF00;
         3'd4:    return 24'hFF00FF;
         3'd5:    return 24'hFF0000;
         3'd6:    return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic logic [23:0] pixel(
      input logic [1:0]  md,
      input logic [23:0] col,
      input logic [7:0]  x,
      input logic [7:0]  y,
      input logic [2:0]  b
   );
      logic [7:0] s;
      s = x + y;
      case (md)
         2'd0:    return col;
         2'd1:    return bar_color(b);
         2'd2:    return {x, y, s};
         default: return (x[3] ^ y[3]) ? 24'h000000 : 24'hFFFFFF;
      endcase
   endfunction

   assign xfer   = tvalid_q & m_axis_tready;
   assign last_x = (x_q == X_LAST);
   assign last_y = (y_q == Y_LAST);
   assign eof    = (state_q == S_ACTIVE) && xfer && last_x && last_y;

`ifdef VIDGEN_INTERFRAME_GAP_EN
   assign gap_take = (frame_gap != 8'd0);
   assign gap_done = (state_q == S_GAP) && (gap_q == 8'd1);
`else
   assign gap_take = 1'b0;
   assign gap_done = 1'b0;
`endif

   assign start = enable && ((state_q == S_IDLE) ||
                             (eof && !gap_take) || gap_done);

   // Position and colour-bar counters for the pixel after the current one
   always_comb begin
      x_d   = x_q + 16'd1;
      y_d   = y_q;
      sub_d = sub_q + 16'd1;
      bar_d = bar_q;
      if (last_x) begin
         x_d   = 16'd0;
         y_d   = last_y ? 16'd0 : y_q + 16'd1;
         sub_d = 16'd0;
         bar_d = 3'd0;
      end else if (sub_q == BAR_LAST) begin
         sub_d = 16'd0;
         if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
      end
   end

   assign pix_nxt   = pixel(mode_q, color_q, x_d[7:0], y_d[7:0], bar_d);
   assign pix_first = pixel(mode, solid_color, 8'd0, 8'd0, 3'd0);

   // Frame FSM with registered stream outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         sub_q       <= '0;
         bar_q       <= '0;
         mode_q      <= '0;
         color_q     <= '0;
         tdata_q     <= '0;
         tvalid_q    <= 1'b0;
         tlast_q     <= 1'b0;
         tuser_q     <= 1'b0;
         busy_q      <= 1'b0;
         frame_cnt_q <= '0;
`ifdef VIDGEN_INTERFRAME_GAP_EN
         gap_q       <= '0;
`endif
      end else begin
         if (eof) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (start) begin
            state_q  <= S_ACTIVE;
            x_q      <= '0;
            y_q      <= '0;
            sub_q    <= '0;
            bar_q    <= '0;
            mode_q   <= mode;
            color_q  <= solid_color;
            tdata_q  <= pix_first;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b1;
            busy_q   <= 1'b1;
         end else begin
            unique case (state_q)
               S_IDLE: begin
               end
               S_ACTIVE: begin
                  if (xfer) begin
                     if (last_x && last_y) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        tuser_q  <= 1'b0;
`ifdef VIDGEN_INTERFRAME_GAP_EN
                        if (gap_take) begin
                           state_q <= S_GAP;
                           gap_q   <= frame_gap;
                        end else
`endif
                        begin
                           state_q <= S_IDLE;
                           busy_q  <= 1'b0;
                        end
                     end else begin
                        x_q     <= x_d;
                        y_q     <= y_d;
                        sub_q   <= sub_d;
                        bar_q   <= bar_d;
                        tdata_q <= pix_nxt;
                        tlast_q <= (x_d == X_LAST);
                        tuser_q <= 1'b0;
                     end
                  end
               end
`ifdef VIDGEN_INTERFRAME_GAP_EN
               S_GAP: begin
                  if (gap_done) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     gap_q <= gap_q - 8'd1;
                  end
               end
`endif
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tuser  = tuser_q;
   assign busy          = busy_q;
   assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// tb_axis_video_pattern_gen: directed bench with a pixel-position model.
// Gap scenario is included when VIDGEN_INTERFRAME_GAP_EN is defined.
module tb_axis_video_pattern_gen;

   localparam int H = 16;
   localparam int V = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [23:0] solid_color = 24'h0;
   logic [7:0]  frame_gap = 8'd0;
   logic [23:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic        busy;
   logic [15:0] frame_cnt;

   int total = 0;
   int bad = 0;

   // model state
   int          px, py;
   logic [15:0] exp_frames;
   int          n_xfer, n_last, n_user;
   int          user_q[$];
   logic [23:0] cap [H*V];
   int          m_mode = 0;
   logic [23:0] m_color = 24'h0;
   bit          stalled;
   logic [23:0] p_data;
   logic        p_last, p_user;

   always #5 clk = ~clk;

   axis_video_pattern_gen #(
      .H_ACTIVE(H),
      .V_ACTIVE(V),
      .DATA_WIDTH(24)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .enable(enable),
      .mode(mode),
      .solid_color(solid_color),
`ifdef VIDGEN_INTERFRAME_GAP_EN
      .frame_gap(frame_gap),
`endif
      .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast),
      .m_axis_tuser(m_axis_tuser),
      .busy(busy),
      .frame_cnt(frame_cnt)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [23:0] model_pix(input int md, input logic [23:0] col,
                                             input int x, input int y);
      int b;
      case (md)
         0: return col;
         1: begin
            b = x / (H / 8);
            if (b > 7) b = 7;
            case (b)
               0: return 24'hFFFFFF;
               1: return 24'hFFFF00;
               2: return 24'h00FFFF;
               3: return 24'h00FF00;
               4: return 24'hFF00FF;
               5: return 24'hFF0000;
               6: return 24'h0000FF;
               default: return 24'h000000;
            endcase
         end
         2: return {8'(x % 256), 8'(y % 256), 8'((x + y) % 256)};
         default: return ((((x / 8) + (y / 8)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
      endcase
   endfunction

   // Per-cycle compare of the stream against the position model
   always @(negedge clk) begin
      if (!reset_n) begin
         px = 0;
         py = 0;
         exp_frames = 16'd0;
         n_xfer = 0;
         n_last = 0;
         n_user = 0;
         user_q.delete();
         stalled = 0;
      end else begin
         chk("frame_cnt", frame_cnt, exp_frames);
         if (m_axis_tvalid) begin
            chk("tdata", m_axis_tdata, model_pix(m_mode, m_color, px, py));
            chk("tlast", m_axis_tlast, px == H - 1);
            chk("tuser", m_axis_tuser, (px == 0) && (py == 0));
            chk("busy_active", busy, 1);
            if (stalled)
               chk("hold", {m_axis_tdata, m_axis_tlast, m_axis_tuser},
                   {p_data, p_last, p_user});
            stalled = !m_axis_tready;
            p_data = m_axis_tdata;
            p_last = m_axis_tlast;
            p_user = m_axis_tuser;
            if (m_axis_tready) begin
               cap[py * H + px] = m_axis_tdata;
               if (m_axis_tlast) n_last++;
               if (m_axis_tuser) begin
                  n_user++;
                  user_q.push_back(n_xfer);
               end
               n_xfer++;
               if (px == H - 1) begin
                  px = 0;
                  if (py == V - 1) begin
                     py = 0;
                     exp_frames = exp_frames + 16'd1;
                  end else begin
                     py++;
                  end
               end else begin
                  px++;
               end
            end
         end else begin
            stalled = 0;
            if (px != 0 || py != 0) chk("tvalid_midframe", m_axis_tvalid, 1);
`ifndef VIDGEN_INTERFRAME_GAP_EN
            else chk("busy_idle", busy, 0);
`endif
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      enable = 1'b0;
      m_axis_tready = 1'b1;
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic start_frame(input int md, input logic [23:0] col);
      mode = 2'(md);
      solid_color = col;
      m_mode = md;
      m_color = col;
      enable = 1'b1;
      tick();
      enable = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int n = 0;
      while ((busy || m_axis_tvalid) && n < budget) begin
         tick();
         n++;
      end
      chk(nm, {busy, m_axis_tvalid}, 2'b00);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // reset then idle
      reset_n = 1'b0;
      tick();
      chk("rst_outs", {m_axis_tdata, m_axis_tvalid, m_axis_tlast,
                       m_axis_tuser, busy, frame_cnt}, 0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_outs", {m_axis_tdata, m_axis_tvalid, m_axis_tlast,
                           m_axis_tuser, busy, frame_cnt}, 0);
      end

      // mid-frame reset at pixel (5,1), ramp
      start_frame(2, 24'h0);
      n = 0;
      while (!(px == 5 && py == 1) && n < 100) begin
         tick();
         n++;
      end
      chk("mr_pixel51", m_axis_tdata, 24'h050106);
      reset_n = 1'b0;
      #1;
      chk("mr_async", {m_axis_tvalid, busy}, 2'b00);
      chk("mr_frame_cnt", frame_cnt, 16'd0);
      enable = 1'b1;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      chk("mr_restart", {m_axis_tvalid, m_axis_tuser, m_axis_tdata},
          {1'b1, 1'b1, 24'h000000});
      enable = 1'b0;
      wait_idle("mr_idle", 200);
      chk("mr_frames", frame_cnt, 16'd1);

      // colour bars, one frame
      do_reset();
      start_frame(1, 24'h0);
      wait_idle("bars_idle", 200);
      chk("bars_xfers", n_xfer, 64);
      chk("bars_tlast", n_last, 4);
      chk("bars_tuser", n_user, 1);
      chk("bars_frames", frame_cnt, 16'd1);
      chk("bars_x0", cap[0], 24'hFFFFFF);
      chk("bars_x1", cap[1], 24'hFFFFFF);
      chk("bars_x3", cap[3], 24'hFFFF00);
      chk("bars_x5", cap[5], 24'h00FFFF);
      chk("bars_x10y1", cap[H + 10], 24'hFF0000);
      chk("bars_x14", cap[14], 24'h000000);
      chk("bars_x15y3", cap[3 * H + 15], 24'h000000);

      // ramp with random backpressure; mid-frame input changes ignored
      do_reset();
      m_axis_tready = 1'b0;
      start_frame(2, 24'h0);
      n = 0;
      while (n_xfer < 64 && n < 1000) begin
         m_axis_tready = 1'($urandom_range(0, 1));
         if (n == 3) begin
            mode = 2'd0;
            solid_color = 24'hABCDEF;
         end
         tick();
         n++;
      end
      m_axis_tready = 1'b1;
      wait_idle("ramp_idle", 200);
      chk("ramp_xfers", n_xfer, 64);
      chk("ramp_pix32", cap[2 * H + 3], 24'h030205);
      chk("ramp_pix153", cap[3 * H + 15], 24'h0F0312);
      chk("ramp_frames", frame_cnt, 16'd1);

      // checkerboard
      do_reset();
      start_frame(3, 24'h0);
      wait_idle("chk_idle", 200);
      chk("chk_x7", cap[7], 24'hFFFFFF);
      chk("chk_x8", cap[8], 24'h000000);

      // back-to-back solid frames
      do_reset();
      mode = 2'd0;
      solid_color = 24'h123456;
      m_mode = 0;
      m_color = 24'h123456;
      enable = 1'b1;
      tick();
      n = 0;
      while (m_axis_tvalid && n < 400) begin
         n++;
         if (n == 150) enable = 1'b0;
         tick();
      end
      enable = 1'b0;
      chk("b2b_run", n, 192);
      wait_idle("b2b_idle", 50);
      chk("b2b_xfers", n_xfer, 192);
      chk("b2b_nuser", user_q.size(), 3);
      if (user_q.size() == 3) begin
         chk("b2b_user0", user_q[0], 0);
         chk("b2b_user1", user_q[1], 64);
         chk("b2b_user2", user_q[2], 128);
      end
      chk("b2b_frames", frame_cnt, 16'd3);
      chk("b2b_pix", cap[5], 24'h123456);

`ifdef VIDGEN_INTERFRAME_GAP_EN
      // inter-frame gap of 5 cycles
      do_reset();
      frame_gap = 8'd5;
      mode = 2'd0;
      solid_color = 24'hABCDEF;
      m_mode = 0;
      m_color = 24'hABCDEF;
      enable = 1'b1;
      tick();
      n = 0;
      while (exp_frames == 16'd0 && n < 200) begin
         tick();
         n++;
      end
      n = 0;
      while (!m_axis_tvalid && n < 50) begin
         chk("gap_busy", busy, 1);
         n++;
         tick();
      end
      chk("gap_len", n, 5);
      chk("gap_tuser", m_axis_tuser, 1);
      enable = 1'b0;
      wait_idle("gap_idle", 200);
      chk("gap_frames", frame_cnt, 16'd2);
      frame_gap = 8'd0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
